// File: rtl/msm_bucket_fifo_if.sv
// Bundle between the point scheduler, the bucket FIFO and the EC point adder.
// master = scheduler/adder side, slave = the FIFO itself.
interface msm_bucket_fifo_if #(
  parameter int DATA_WIDTH  = 180,
  parameter int INDEX_WIDTH = 4,
  parameter int DEPTH       = 15
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                   clear;
  logic                   we;
  logic [DATA_WIDTH-1:0]  pin;
  logic [INDEX_WIDTH-1:0] index_in;
  logic                   re;
  logic [DATA_WIDTH-1:0]  pout;
  logic [INDEX_WIDTH-1:0] index_out;
  logic                   out_valid;
  logic                   full;
  logic                   empty;
  logic                   almost_full;
  logic                   almost_empty;
  logic [CNT_W-1:0]       level;
  logic                   overflow;
  logic                   underflow;

  modport master (
    output clear, we, pin, index_in, re,
    input  pout, index_out, out_valid, full, empty,
           almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  clear, we, pin, index_in, re,
    output pout, index_out, out_valid, full, empty,
           almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/msm_bucket_fifo.sv
// Point/bucket-index FIFO for MSM bucket accumulation. Holds {index, point pair}
// while the target bucket is busy. Any DEPTH >= 2, optional first-word-fall-through,
// programmable almost flags, sticky overflow/underflow and a synchronous flush.
module msm_bucket_fifo #(
  parameter int PW          = 30,
  parameter int DATA_WIDTH  = 6 * PW,
  parameter int INDEX_WIDTH = 4,
  parameter int DEPTH       = 15,
  parameter bit FWFT        = 1'b0,
  parameter int AF_LEVEL    = DEPTH - 2,
  parameter int AE_LEVEL    = 2
) (
  input  logic             clk,
  input  logic             rst,
  msm_bucket_fifo_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = INDEX_WIDTH + DATA_WIDTH;

  // Pointers wrap at DEPTH-1 explicitly, so non-power-of-2 depths work.
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  // Entry storage; deliberately not reset, pointers/level define validity.
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [ENT_W-1:0] dout_q, dout_d;
  logic             vld_q, vld_d;

  logic             full_w, empty_w;
  logic             rd_ok, wr_ok;
  logic [ENT_W-1:0] head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_w  = (level_q == FULL_LVL);
  assign empty_w = (level_q == '0);
  assign rd_ok   = bus.re & ~empty_w;
  // A pop in the same cycle frees a slot, so a write at full is still taken.
  assign wr_ok   = bus.we & (~full_w | rd_ok);
  assign head    = mem_q[rd_ptr_q];

  // Next-state: pointers, occupancy, sticky errors and the registered read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    dout_d   = dout_q;
    vld_d    = 1'b0;
    if (bus.clear) begin
      // Flush wins over same-cycle requests; they are dropped without error.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
      dout_d   = '0;
    end else begin
      if (wr_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
        dout_d   = head;
        vld_d    = 1'b1;
      end
      if (wr_ok && !rd_ok)      level_d = level_q + CNT_W'(1);
      else if (rd_ok && !wr_ok) level_d = level_q - CNT_W'(1);
      if (bus.we && !wr_ok) ovf_d = 1'b1;
      if (bus.re && empty_w) udf_d = 1'b1;
    end
  end

  // State registers; async reset returns an all-zero output, i.e. "no bucket".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
      vld_q    <= vld_d;
    end
  end

  // Storage write; a flush drops the same-cycle write.
  always_ff @(posedge clk) begin
    if (wr_ok && !bus.clear) mem_q[wr_ptr_q] <= {bus.index_in, bus.pin};
  end

  // FWFT exposes the head entry directly; otherwise the one-cycle read register.
  assign bus.pout      = FWFT ? head[DATA_WIDTH-1:0]     : dout_q[DATA_WIDTH-1:0];
  assign bus.index_out = FWFT ? head[ENT_W-1:DATA_WIDTH] : dout_q[ENT_W-1:DATA_WIDTH];
  assign bus.out_valid = FWFT ? ~empty_w : vld_q;

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (int'(level_q) >= AF_LEVEL);
  assign bus.almost_empty = (int'(level_q) <= AE_LEVEL);
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_msm_bucket_fifo.sv
// Scoreboard bench: stimulus pushes expected read data into exp_q, a monitor
// branch pops/compares whenever the registered-read FIFO presents out_valid.
// A second FWFT instance (DEPTH=5) is checked with direct vectors.
module tb_msm_bucket_fifo;
  localparam int PW    = 30;
  localparam int DW    = 6 * PW;
  localparam int IW    = 4;
  localparam int DA    = 15;
  localparam int DB    = 5;
  localparam int ENT_W = IW + DW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  msm_bucket_fifo_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DA)) ifa ();
  msm_bucket_fifo_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DB)) ifb ();

  msm_bucket_fifo #(.PW(PW), .DEPTH(DA), .FWFT(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  msm_bucket_fifo #(.PW(PW), .DEPTH(DB), .FWFT(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  int nvec = 0;
  int nerr = 0;
  bit done = 1'b0;
  logic [ENT_W-1:0] mdl[$];
  logic [ENT_W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock on FIFO A; the reference queue follows the accept rules.
  task automatic step_a(input bit c, input bit w, input bit r, input int idx, input int pay);
    bit e, f, rok, wok;
    e   = (mdl.size() == 0);
    f   = (mdl.size() == DA);
    rok = r && !e;
    wok = w && (!f || rok);
    ifa.clear = c; ifa.we = w; ifa.re = r;
    ifa.index_in = IW'(idx); ifa.pin = DW'(pay);
    @(posedge clk);
    if (c) mdl.delete();
    else begin
      if (rok) exp_q.push_back(mdl.pop_front());
      if (wok) mdl.push_back({IW'(idx), DW'(pay)});
    end
    #1;
    ifa.clear = 1'b0; ifa.we = 1'b0; ifa.re = 1'b0;
  endtask

  task automatic step_b(input bit w, input bit r, input int idx, input int pay);
    ifb.we = w; ifb.re = r;
    ifb.index_in = IW'(idx); ifb.pin = DW'(pay);
    @(posedge clk);
    #1;
    ifb.we = 1'b0; ifb.re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ifa.clear = 0; ifa.we = 0; ifa.re = 0; ifa.pin = '0; ifa.index_in = '0;
    ifb.clear = 0; ifb.we = 0; ifb.re = 0; ifb.pin = '0; ifb.index_in = '0;
    #1 rst = 1'b1;
    #2;
    chk("rst_level",  32'(ifa.level), 0);
    chk("rst_empty",  32'(ifa.empty), 1);
    chk("rst_aempty", 32'(ifa.almost_empty), 1);
    chk("rst_full",   32'(ifa.full), 0);
    chk("rst_afull",  32'(ifa.almost_full), 0);
    chk("rst_valid",  32'(ifa.out_valid), 0);
    chk("rst_index",  32'(ifa.index_out), 0);
    chk("rst_pout",   32'(ifa.pout != '0), 0);
    chk("rst_ovf",    32'(ifa.overflow), 0);
    chk("rst_udf",    32'(ifa.underflow), 0);
    chk("rstB_empty", 32'(ifb.empty), 1);
    chk("rstB_valid", 32'(ifb.out_valid), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    fork
      begin : stim
        // Fill 15: index=i, payload=i*3; flags track the level.
        for (int i = 1; i <= 15; i++) begin
          step_a(0, 1, 0, i, i * 3);
          chk("fill_level",  32'(ifa.level), i);
          chk("fill_full",   32'(ifa.full), 32'(i == 15));
          chk("fill_afull",  32'(ifa.almost_full), 32'(i >= 13));
          chk("fill_aempty", 32'(ifa.almost_empty), 32'(i <= 2));
        end
        for (int i = 1; i <= 15; i++) step_a(0, 0, 1, 0, 0);
        step_a(0, 0, 0, 0, 0);
        chk("drain_empty", 32'(ifa.empty), 1);
        chk("drain_level", 32'(ifa.level), 0);

        // Full, then simultaneous push/pop with wrapping pointers.
        for (int i = 1; i <= 15; i++) step_a(0, 1, 0, i, 100 + i);
        chk("full2", 32'(ifa.full), 1);
        for (int k = 0; k < 20; k++) begin
          step_a(0, 1, 1, (k % 15) + 1, 200 + k);
          chk("swap_level", 32'(ifa.level), 15);
          chk("swap_ovf",   32'(ifa.overflow), 0);
        end
        step_a(0, 1, 0, 9, 999);
        chk("ovf_set",   32'(ifa.overflow), 1);
        chk("ovf_level", 32'(ifa.level), 15);
        for (int i = 0; i < 15; i++) step_a(0, 0, 1, 0, 0);
        step_a(0, 0, 0, 0, 0);
        chk("ovf_sticky", 32'(ifa.overflow), 1);
        chk("drain2_empty", 32'(ifa.empty), 1);

        // Level 6 with overflow set, then clear together with a write.
        for (int i = 1; i <= 6; i++) step_a(0, 1, 0, i, 50 + i);
        chk("pre_clr_level", 32'(ifa.level), 6);
        chk("pre_clr_ovf",   32'(ifa.overflow), 1);
        step_a(1, 1, 0, 4, 77);
        chk("clr_level", 32'(ifa.level), 0);
        chk("clr_ovf",   32'(ifa.overflow), 0);
        chk("clr_empty", 32'(ifa.empty), 1);
        chk("clr_pout",  32'(ifa.pout != '0), 0);
        chk("clr_index", 32'(ifa.index_out), 0);

        // Read+write at empty: write taken, read rejected.
        step_a(0, 1, 1, 5, 555);
        chk("udf_set",   32'(ifa.underflow), 1);
        chk("udf_level", 32'(ifa.level), 1);
        chk("udf_valid", 32'(ifa.out_valid), 0);
        step_a(0, 0, 1, 0, 0);
        step_a(0, 0, 0, 0, 0);
        chk("udf_sticky", 32'(ifa.underflow), 1);

        // Async reset mid-stream at level 9, checked before any clock edge.
        for (int i = 1; i <= 9; i++) step_a(0, 1, 0, i, 300 + i);
        chk("pre_rst_level", 32'(ifa.level), 9);
        rst = 1'b1;
        #2;
        mdl.delete();
        chk("arst_level",  32'(ifa.level), 0);
        chk("arst_empty",  32'(ifa.empty), 1);
        chk("arst_aempty", 32'(ifa.almost_empty), 1);
        chk("arst_afull",  32'(ifa.almost_full), 0);
        chk("arst_udf",    32'(ifa.underflow), 0);
        chk("arst_index",  32'(ifa.index_out), 0);
        chk("arst_pout",   32'(ifa.pout != '0), 0);
        chk("arst_valid",  32'(ifa.out_valid), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        step_a(0, 1, 0, 11, 4242);
        chk("post_rst_level", 32'(ifa.level), 1);
        step_a(0, 0, 1, 0, 0);
        step_a(0, 0, 0, 0, 0);
        chk("post_rst_empty", 32'(ifa.empty), 1);

        // FWFT instance.
        step_b(1, 0, 3, 33);
        chk("fwft_valid1", 32'(ifb.out_valid), 1);
        chk("fwft_idx1",   32'(ifb.index_out), 3);
        chk("fwft_pout1",  32'(ifb.pout), 33);
        step_b(1, 0, 7, 77);
        chk("fwft_idx_hold", 32'(ifb.index_out), 3);
        chk("fwft_level2",   32'(ifb.level), 2);
        step_b(0, 1, 0, 0);
        chk("fwft_idx2",   32'(ifb.index_out), 7);
        chk("fwft_pout2",  32'(ifb.pout), 77);
        chk("fwft_valid2", 32'(ifb.out_valid), 1);
        step_b(0, 1, 0, 0);
        chk("fwft_valid3", 32'(ifb.out_valid), 0);
        chk("fwft_empty",  32'(ifb.empty), 1);
        done = 1'b1;
      end
      begin : mon
        logic [ENT_W-1:0] ent;
        while (!done) begin
          @(negedge clk);
          if (ifa.out_valid === 1'b1 || exp_q.size() > 0) begin
            nvec++;
            if (exp_q.size() == 0) begin
              nerr++;
              $display("FAIL rdata: unexpected out_valid idx=%0d at %0t", ifa.index_out, $time);
            end else begin
              ent = exp_q.pop_front();
              if (ifa.out_valid !== 1'b1 || {ifa.index_out, ifa.pout} !== ent) begin
                nerr++;
                $display("FAIL rdata: got valid=%b idx=%0d pay=%0d expected idx=%0d pay=%0d at %0t",
                         ifa.out_valid, ifa.index_out, ifa.pout,
                         ent[ENT_W-1:DW], ent[DW-1:0], $time);
              end
            end
          end
        end
      end
    join

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/msm_bucket_fifo.md
Name: msm_bucket_fifo

Overview:
- Parametrised point/index buffering FIFO for the MSM bucket-accumulation datapath.
- Sits between the point scheduler and the EC point adder. Queues a projective point pair together with its bucket index while the target bucket is busy.
- Adds non-power-of-2 depth, correct count width, selectable first-word-fall-through (FWFT) mode, programmable almost-full/almost-empty flags, level output, sticky overflow/underflow errors, and a synchronous flush.

Parameters:
- PW, 30: width of one coordinate.
- DATA_WIDTH, 6*PW: payload width (point pair, 3 coordinates x 2 points).
- INDEX_WIDTH, 4: bucket index width.
- DEPTH, 15: number of entries, any value >= 2.
- FWFT, 0: 0 = registered read with 1-cycle latency; 1 = first-word-fall-through.
- AF_LEVEL, DEPTH-2: almost_full asserted when level >= AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserted when level <= AE_LEVEL.
- Derived, not overridable: PTR_W = $clog2(DEPTH); CNT_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush
- we  in  1  write request
- pin  in  DATA_WIDTH  point payload in
- index_in  in  INDEX_WIDTH  bucket index in
- re  in  1  read request (pop)
- pout  out  DATA_WIDTH  point payload out
- index_out  out  INDEX_WIDTH  bucket index out
- out_valid  out  1  pout/index_out hold valid data
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LEVEL
- almost_empty  out  1  level <= AE_LEVEL
- level  out  CNT_W  current occupancy
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

Behaviour:
- Storage: DEPTH entries of {index, payload}. Write and read pointers wrap from DEPTH-1 to 0. Storage contents are not reset.
- rd_ok = re & !empty.
- wr_ok = we & (!full | rd_ok). At full, a simultaneous read frees a slot, so both are accepted.
- level update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur.
- At empty, re & we: the write is accepted, the read is rejected, underflow is set, and level becomes 1.
- overflow is set on we & !wr_ok. underflow is set on re & empty. Both stay set until rst or clear.
- FWFT=0:
  - On rd_ok, {index_out, pout} <= head entry at the next edge, and out_valid=1 for exactly that one cycle.
  - Otherwise the outputs hold their last value and out_valid=0.
- FWFT=1:
  - {index_out, pout} = head entry (combinational from the read pointer).
  - out_valid = !empty.
  - re pops the head; the next entry is visible in the same cycle the pointer advances.
- Flags full, empty, almost_full, almost_empty are combinational from level.
- Reset (async):
  - level=0, both pointers=0, pout=0, index_out=0, out_valid=0, overflow=0, underflow=0.
  - Flag values after reset: empty=1, almost_empty=1, full=0, almost_full=0 (given AF_LEVEL>0).
  - Index 0 means "no bucket"; the reset output therefore never addresses a real bucket.
- clear (sync): same effect as reset at the next edge. clear has priority over we/re in the same cycle; those requests are dropped and do not set the error flags.
- Reset asserted mid-operation discards all entries; the first write after rst deasserts lands in slot 0.

Test Plan:
- Defaults (DEPTH=15, FWFT=0): write 15 entries, index=i, payload=i*3. Required: full after the 15th write, level=15, almost_full from level 13. Then read all 15: index_out sequence 1..15 in order, out_valid one cycle after each re, empty at the end.
- Fill to full, then 20 cycles of simultaneous we/re. Required: level stays 15, pointers wrap past 14->0, output order preserved, overflow stays 0. A 16th write without re sets overflow=1 and leaves level=15.
- Empty FIFO, assert re & we together with index=5. Required: underflow=1, level=1, out_valid=0. The next re outputs index_out=5.
- FWFT=1, DEPTH=5: write indexes 3 then 7. Required: index_out=3 with out_valid=1 in the cycle after the first write. After one re, index_out=7 immediately. After a second re, out_valid=0.
- Level=6 with overflow set; pulse clear together with we. Required: level=0, overflow=0, empty=1, the write is dropped, pout=0.
- Assert rst asynchronously mid-stream (level=9). Required: all outputs reach reset values without a clock edge. The next write plus read returns that newly written entry.
